// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment type, off pattern and hex-to-segment lookup
//
// Purpose: common definitions for the 7-segment scan controller.
//   seg_t      : {dp,g,f,e,d,c,b,a}, active-high
//   SEG_OFF    : all segments dark (active-high)
//   hex2seg()  : nibble -> active-high segment pattern, dp bit clear

package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'h00;

  function automatic seg_t hex2seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// rtl/seg_hex_dec.sv - combinational nibble plus decimal point to segment pattern
//
// Purpose: decode one hex digit and its decimal point into an active-high seg_t.
// Ports:
//   nibble  in   4   hex value to show
//   dp      in   1   decimal point
//   seg     out  8   {dp,g,f,e,d,c,b,a}, active-high

module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output seg_t       seg
);

  assign seg = hex2seg(nibble) | {dp, 7'b000_0000};

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with tear-free load
//
// Purpose: scans NDIG hex digits onto shared segment lines, blanks the start of
// every slot against ghosting, suppresses leading zeros, and swaps in newly
// loaded data only at frame boundaries, acknowledging each commit.
// Ports:
//   clk         in   1        system clock
//   rst         in   1        asynchronous, active-low reset
//   value_i     in   4*NDIG   hex nibbles, digit 0 = value_i[3:0]
//   dp_i        in   NDIG     decimal point per digit
//   load_i      in   1        strobe: capture value_i/dp_i into the pending buffer
//   en_i        in   1        display enable, 0 blanks all digits
//   lz_supp_i   in   1        leading-zero suppression enable
//   load_ack_o  out  1        pulse: pending buffer committed to display
//   seg_o       out  8        {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LO
//   dig_o       out  NDIG     one-hot digit select, polarity per DIG_ACT_LO

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG       = 8,
  parameter int SCAN_DIV   = 12500,
  parameter int BLANK_CYC  = 16,
  parameter bit SEG_ACT_LO = 1'b1,
  parameter bit DIG_ACT_LO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] value_i,
  input  logic [NDIG-1:0]   dp_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic              lz_supp_i,
  output logic              load_ack_o,
  output logic [7:0]        seg_o,
  output logic [NDIG-1:0]   dig_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam seg_t            SEG_IDLE = SEG_ACT_LO ? ~SEG_OFF : SEG_OFF;
  localparam logic [NDIG-1:0] DIG_IDLE = DIG_ACT_LO ? {NDIG{1'b1}} : {NDIG{1'b0}};

  generate
    if (SCAN_DIV <= BLANK_CYC) begin : g_bad_div
      $error("seg_scan_ctrl: SCAN_DIV must exceed BLANK_CYC");
    end
    if (NDIG < 1) begin : g_bad_ndig
      $error("seg_scan_ctrl: NDIG must be at least 1");
    end
  endgenerate

  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic              slot_wrap;
  logic              last_dig;
  logic              frame_end;

  logic [4*NDIG-1:0] pend_val;
  logic [NDIG-1:0]   pend_dp;
  logic              pending;
  logic [4*NDIG-1:0] disp_val;
  logic [NDIG-1:0]   disp_dp;

  logic [NDIG-1:0]   lz_blank;
  logic              all_zero;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_lz;
  logic [NDIG-1:0]   dig_hot;
  logic              slot_dark;
  seg_t              dec_seg;
  seg_t              seg_hi;
  logic [NDIG-1:0]   dig_hi;

  // Prescaler and digit counter
  assign slot_wrap = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign last_dig  = (dig_idx == IDX_W'(NDIG - 1));
  assign frame_end = slot_wrap && last_dig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (slot_wrap) begin
      div_cnt <= '0;
      dig_idx <= last_dig ? '0 : dig_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Pending and display buffers. The commit reads the pre-edge pending
  // buffer, so a load landing on frame_end waits for the next frame while
  // the older pending data is shown now.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      load_ack_o <= 1'b0;
    end else begin
      load_ack_o <= frame_end && pending;
      if (frame_end && pending) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        pending  <= 1'b0;
      end
      if (load_i) begin
        pend_val <= value_i;
        pend_dp  <= dp_i;
        pending  <= 1'b1;
      end
    end
  end

  // Leading-zero mask: digit i goes dark when it and every digit above it is
  // zero. Digit 0 is always shown so a zero value still reads "0".
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      all_zero    = all_zero && (disp_val[4*i +: 4] == 4'h0);
      lz_blank[i] = all_zero;
    end
  end

  // Select the current digit's data and its one-hot enable
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    dig_hot = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        cur_nib    = disp_val[4*i +: 4];
        cur_dp     = disp_dp[i];
        cur_lz     = lz_blank[i];
        dig_hot[i] = 1'b1;
      end
    end
  end

  seg_hex_dec u_hex_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

  assign slot_dark = (div_cnt < DIV_W'(BLANK_CYC)) || !en_i || (lz_supp_i && cur_lz);
  assign seg_hi    = slot_dark ? SEG_OFF : dec_seg;
  assign dig_hi    = slot_dark ? '0 : dig_hot;

  // Registered pins: single driver per digit line, no decode glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_o <= SEG_IDLE;
      dig_o <= DIG_IDLE;
    end else begin
      seg_o <= SEG_ACT_LO ? ~seg_hi : seg_hi;
      dig_o <= DIG_ACT_LO ? ~dig_hi : dig_hi;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl against a frame-level model

module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 8;
  localparam int BLK  = 2;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        en;
  logic        lz;
  logic        load_ack_o;
  logic [7:0]  seg_o;
  logic [3:0]  dig_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          t;
  logic [15:0] m_pend;
  logic [3:0]  m_pdp;
  bit          m_pending;
  logic [15:0] m_disp;
  logic [3:0]  m_ddp;
  logic [7:0]  hex_tab [16];

  seg_scan_ctrl #(
    .NDIG       (NDIG),
    .SCAN_DIV   (DIV),
    .BLANK_CYC  (BLK),
    .SEG_ACT_LO (1'b1),
    .DIG_ACT_LO (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value),
    .dp_i       (dp),
    .load_i     (load),
    .en_i       (en),
    .lz_supp_i  (lz),
    .load_ack_o (load_ack_o),
    .seg_o      (seg_o),
    .dig_o      (dig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int pos_div();
    return t % DIV;
  endfunction

  function automatic int pos_idx();
    return (t / DIV) % NDIG;
  endfunction

  function automatic void model_reset();
    t         = 0;
    m_pend    = '0;
    m_pdp     = '0;
    m_pending = 0;
    m_disp    = '0;
    m_ddp     = '0;
  endfunction

  // One clock: predict pins from the model, clock, compare, advance the model.
  task automatic step();
    int          d;
    int          k;
    bit          fe;
    bit          dark;
    logic [3:0]  nib;
    logic [7:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_ack;
    d     = pos_div();
    k     = pos_idx();
    fe    = (d == DIV - 1) && (k == NDIG - 1);
    e_ack = fe && m_pending;
    dark  = (d < BLK) || !en || (lz && k > 0 && ((m_disp >> (4 * k)) == 16'h0));
    nib   = 4'((m_disp >> (4 * k)) & 16'hF);
    if (dark) begin
      e_seg = 8'hFF;
      e_dig = 4'hF;
    end else begin
      e_seg = ~(hex_tab[nib] | (m_ddp[k] ? 8'h80 : 8'h00));
      e_dig = ~(4'b0001 << k);
    end
    @(posedge clk);
    #1;
    chk("seg", 32'(seg_o), 32'(e_seg));
    chk("dig", 32'(dig_o), 32'(e_dig));
    chk("ack", 32'(load_ack_o), 32'(e_ack));
    if (fe && m_pending) begin
      m_disp    = m_pend;
      m_ddp     = m_pdp;
      m_pending = 0;
    end
    if (load) begin
      m_pend    = value;
      m_pdp     = dp;
      m_pending = 1;
    end
    t++;
    load = 1'b0;
  endtask

  task automatic goto_pos(input int k, input int d);
    int n = 0;
    while (!(pos_idx() == k && pos_div() == d) && n < 64) begin
      step();
      n++;
    end
    chk("goto_bound", 32'(n < 64), 32'd1);
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] p);
    value = v;
    dp    = p;
    load  = 1'b1;
    step();
  endtask

  task automatic wait_ack();
    bit seen = 0;
    for (int n = 0; n < 48 && !seen; n++) begin
      step();
      if (load_ack_o) seen = 1;
    end
    chk("ack_wait", 32'(seen), 32'd1);
  endtask

  task automatic show_at(input string tag, input int k, input int d,
                         input logic [7:0] e_seg, input logic [3:0] e_dig);
    goto_pos(k, d);
    step();
    chk({tag, "_seg"}, 32'(seg_o), 32'(e_seg));
    chk({tag, "_dig"}, 32'(dig_o), 32'(e_dig));
  endtask

  initial begin
    hex_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    rst   = 1'b0;
    value = '0;
    dp    = '0;
    load  = 1'b0;
    en    = 1'b1;
    lz    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // Run into a lit slot, then assert reset mid-slot and check pins at once
    load_val(16'h8888, 4'hF);
    wait_ack();
    goto_pos(1, 4);
    rst = 1'b0;
    #1;
    chk("rst_seg", 32'(seg_o), 32'hFF);
    chk("rst_dig", 32'(dig_o), 32'hF);
    chk("rst_ack", 32'(load_ack_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // Basic load/commit and decoded digits
    load_val(16'h12AF, 4'h0);
    wait_ack();
    show_at("d0_F", 0, 2, 8'h8E, 4'b1110);
    show_at("d0_end", 0, 7, 8'h8E, 4'b1110);
    show_at("d3_1", 3, 4, 8'hF9, 4'b0111);
    show_at("blank0", 2, 0, 8'hFF, 4'hF);
    show_at("blank1", 2, 1, 8'hFF, 4'hF);

    // Leading-zero suppression
    lz = 1'b1;
    load_val(16'h0005, 4'h0);
    wait_ack();
    show_at("lz5_d0", 0, 4, 8'h92, 4'b1110);
    show_at("lz5_d2", 2, 4, 8'hFF, 4'hF);
    load_val(16'h0000, 4'b0010);
    wait_ack();
    show_at("lz0_d0", 0, 4, 8'hC0, 4'b1110);
    show_at("lz0_d1", 1, 4, 8'hFF, 4'hF);
    lz = 1'b0;

    // Two loads in one frame: one ack, latest value wins
    begin
      int acks = 0;
      goto_pos(0, 1);
      load_val(16'h1111, 4'h0);
      step();
      load_val(16'h2222, 4'h0);
      for (int n = 0; n < 40; n++) begin
        step();
        if (load_ack_o) acks++;
      end
      chk("one_ack", 32'(acks), 32'd1);
      show_at("latest", 0, 4, 8'hA4, 4'b1110);
    end

    // Load exactly on frame_end with display disabled
    en = 1'b0;
    goto_pos(NDIG - 1, DIV - 1);
    load_val(16'h3456, 4'h0);
    chk("fe_no_ack", 32'(load_ack_o), 32'd0);
    goto_pos(NDIG - 1, DIV - 1);
    step();
    chk("fe_ack", 32'(load_ack_o), 32'd1);
    chk("fe_dark", 32'(dig_o), 32'hF);
    en = 1'b1;

    // Randomised traffic, with extra loads aimed at frame_end
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) lz = ~lz;
      if (pos_div() == DIV - 1 && pos_idx() == NDIG - 1)
        load = ($urandom_range(0, 1) == 1);
      else
        load = ($urandom_range(0, 19) == 0);
      // Bias toward zero-heavy values so suppression gets exercised
      value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp    = 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
